// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module  : shift_seq_pkg
// Brief   : Shared widths, FSM states, directions and datapath op codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_ROR  = 2'd2;
  localparam logic [1:0] OP_ROL  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/shift_core.sv
// ============================================================================
// Module  : shift_core
// Brief   : Working register with load / rotate-right / rotate-left / hold.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    case (op_i)
      OP_LOAD: data_d = data_i;
      OP_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
      OP_ROL:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module  : shift_sequencer
// Brief   : Multi-cycle 1-bit-per-cycle rotator with valid/ready handshakes.
//           Option macro: SHIFT_SEQUENCER_SHORTEST_EN (shortest-path rotate).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy
);

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             res_valid_q;

  logic [AMT_W-1:0] cnt_d;
  logic             dir_d;
  logic             accept;
  logic             res_take;
  logic [1:0]       core_op;

  assign accept   = cmd_valid & cmd_ready_q;
  assign res_take = res_valid_q & res_ready;

`ifdef SHIFT_SEQUENCER_SHORTEST_EN
  // Rotating by N one way equals rotating by WIDTH-N the other way.
  always_comb begin
    cnt_d = cmd_amt;
    dir_d = cmd_dir;
    if (cmd_amt > AMT_W'(WIDTH / 2)) begin
      cnt_d = AMT_W'(WIDTH - int'(cmd_amt));
      dir_d = ~cmd_dir;
    end
  end
`else
  assign cnt_d = cmd_amt;
  assign dir_d = cmd_dir;
`endif

  always_comb begin
    core_op = OP_HOLD;
    case (state_q)
      IDLE:    if (accept) core_op = OP_LOAD;
      SHIFT:   core_op = (dir_q == DIR_LEFT) ? OP_ROL : OP_ROR;
      default: core_op = OP_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_RIGHT;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cnt_d != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_take) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .op_i   (core_op),
    .data_i (cmd_data),
    .data_o (res_data)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign msb_out   = res_data[WIDTH-1];
  assign lsb_out   = res_data[0];

endmodule

`default_nettype wire
